// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: holds the video domain in reset until PLL lock is stable, then runs a pixel enable
module pll_lock_reset_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int DIV                = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock_async,
    output logic       rst_out,
    output logic       pll_ready,
    output logic       pix_en,
    output logic       lost_lock,
    output logic [7:0] lock_loss_count
);
    localparam int MAXC = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int DW   = $clog2(DIV + 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (LOCK_STABLE_CYCLES < 1) begin : g_bad_stable
        $error("LOCK_STABLE_CYCLES must be >= 1");
    end
    if (RST_HOLD_CYCLES < 1) begin : g_bad_hold
        $error("RST_HOLD_CYCLES must be >= 1");
    end
    if (DIV < 1) begin : g_bad_div
        $error("DIV must be >= 1");
    end

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic [DW-1:0]          div_cnt;
    logic                   lock_sync;

    assign lock_sync = sync[SYNC_STAGES-1];
    assign rst_out   = (state != RUN);
    assign pll_ready = (state == RUN);
    assign pix_en    = (state == HOLD || state == RUN) && div_cnt == DW'(DIV - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync            <= '0;
            state           <= WAIT_LOCK;
            cnt             <= '0;
            div_cnt         <= '0;
            lost_lock       <= 1'b0;
            lock_loss_count <= '0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], lock_async};
            lost_lock <= 1'b0;
            if (state == HOLD || state == RUN)
                div_cnt <= (div_cnt == DW'(DIV - 1)) ? '0 : div_cnt + 1'b1;
            // any lock drop restarts from WAIT_LOCK with clean counters, winning over terminal counts
            if (!lock_sync) begin
                state   <= WAIT_LOCK;
                cnt     <= '0;
                div_cnt <= '0;
                if (state == RUN) begin
                    lost_lock <= 1'b1;
                    if (lock_loss_count != 8'hff)
                        lock_loss_count <= lock_loss_count + 1'b1;
                end
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        state   <= STABLE;
                        cnt     <= '0;
                        div_cnt <= '0;
                    end
                    STABLE: begin
                        if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
                            state   <= HOLD;
                            cnt     <= '0;
                            div_cnt <= '0;
                        end else
                            cnt <= cnt + 1'b1;
                    end
                    HOLD: begin
                        if (cnt == CW'(RST_HOLD_CYCLES - 1))
                            state <= RUN;
                        else
                            cnt <= cnt + 1'b1;
                    end
                    RUN: state <= RUN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb_pll_lock_reset_seq: random lock stimulus checked against a lock-streak reference model
module tb_pll_lock_reset_seq;
    localparam int SS = 2;
    localparam int L  = 8;
    localparam int H  = 4;
    localparam int D  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock_async = 1'b1;
    logic       rst_out, pll_ready, pix_en, lost_lock;
    logic [7:0] lock_loss_count;

    int vectors = 0;
    int errors  = 0;

    // model: s counts consecutive edges at which the synchronised lock was high
    int s = 0;
    int cnt_m = 0;
    bit ll_m = 0;
    bit hist[$];

    pll_lock_reset_seq #(
        .SYNC_STAGES(SS), .LOCK_STABLE_CYCLES(L), .RST_HOLD_CYCLES(H), .DIV(D)
    ) dut (
        .clk(clk), .rst(rst), .lock_async(lock_async), .rst_out(rst_out),
        .pll_ready(pll_ready), .pix_en(pix_en), .lost_lock(lost_lock),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit l);
        bit ls;
        rst = r;
        lock_async = l;
        @(posedge clk);
        ll_m = 0;
        if (r) begin
            s = 0;
            cnt_m = 0;
            hist.delete();
            repeat (SS) hist.push_back(1'b0);
        end else begin
            ls = hist.pop_front();
            hist.push_back(l);
            if (!ls) begin
                if (s > L + H) begin
                    ll_m = 1;
                    if (cnt_m < 255) cnt_m++;
                end
                s = 0;
            end else if (s < 100000) s++;
        end
        #1;
        check("rst_out", {7'd0, rst_out}, {7'd0, !(s > L + H)});
        check("pll_ready", {7'd0, pll_ready}, {7'd0, s > L + H});
        check("pix_en", {7'd0, pix_en}, {7'd0, s > L && (s - L - 1) % D == D - 1});
        check("lost_lock", {7'd0, lost_lock}, {7'd0, ll_m});
        check("count", lock_loss_count, cnt_m[7:0]);
    endtask

    // release must come in cycle SS+1+L+H counted from the first edge sampling lock high
    task automatic measure_release();
        int n;
        n = 0;
        while (n < 40) begin
            n++;
            step(0, 1);
            if (pll_ready) break;
        end
        check("release", n[7:0], 8'(SS + 1 + L + H));
    endtask

    initial begin
        repeat (SS) hist.push_back(1'b0);
        repeat (3) step(1, 1);
        measure_release();
        repeat (20) step(0, 1);
        // glitch mid-STABLE, then the whole sequence must restart
        repeat (3) step(1, 1);
        repeat (SS + 6) step(0, 1);
        step(0, 0);
        repeat (30) step(0, 1);
        // loss from RUN
        repeat (3) step(0, 0);
        measure_release();
        // reset in HOLD
        repeat (3) step(1, 1);
        repeat (SS + 1 + L + 2) step(0, 1);
        step(1, 1);
        measure_release();
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 25)) step(0, 1);
            repeat ($urandom_range(1, 4)) step(0, 0);
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 2)) step(1, $urandom_range(0, 1));
        end
        for (int i = 0; i < 257; i++) begin
            repeat (20 + $urandom_range(0, 4)) step(0, 1);
            repeat (3) step(0, 0);
        end
        repeat (5) step(0, 1);
        check("saturated", lock_loss_count, 8'd255);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
